// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    EW_G  = 3'd2,
    EW_Y  = 3'd3,
    NIGHT = 3'd4
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Elaboration-time conversion of a 0..99 value to a {tens, ones} BCD pair.
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/traffic_ctrl_sec_prescaler.sv
// One-second time base: registered tick high while the count sits at CLK_HZ-1.
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST     = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLK_HZ - 2);

  logic [CW-1:0] count;

  // tick is registered one count early so it coincides with count == LAST.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      if (count == LAST) count <= '0;
      else               count <= count + CW'(1);
      tick <= (count == PRE_LAST);
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Two-road traffic-light sequencer with BCD countdown and flashing-yellow night mode.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int GREEN_S  = 25,
  parameter int YELLOW_S = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       night,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [3:0] digit_hi,
  output logic [3:0] digit_lo,
  output logic       sec_tick
);

  localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_S);
  localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_S);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       flash, flash_nx;
  logic       clr;
  logic [2:0] ns_nx, ew_nx;

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (sec_tick)
  );

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    flash_nx = flash;
    clr      = 1'b0;
    if (state == NIGHT) begin
      if (!night) begin
        state_nx = NS_G;
        cnt_nx   = GREEN_BCD;
        flash_nx = 1'b0;
        clr      = 1'b1;
      end else if (sec_tick) begin
        flash_nx = ~flash;
      end
    end else if (night) begin
      // night wins over a coincident tick: no advance, no reload
      state_nx = NIGHT;
      cnt_nx   = {DIGIT_BLANK, DIGIT_BLANK};
      flash_nx = 1'b1;
      clr      = 1'b1;
    end else if (sec_tick) begin
      if (cnt == 8'h01) begin
        case (state)
          NS_G:    begin state_nx = NS_Y; cnt_nx = YELLOW_BCD; end
          NS_Y:    begin state_nx = EW_G; cnt_nx = GREEN_BCD;  end
          EW_G:    begin state_nx = EW_Y; cnt_nx = YELLOW_BCD; end
          default: begin state_nx = NS_G; cnt_nx = GREEN_BCD;  end
        endcase
      end else begin
        cnt_nx = bcd_dec(cnt);
      end
    end
  end

  // Lamps are decoded from the next state so they register on the same edge.
  always_comb begin
    ns_nx = RED;
    ew_nx = RED;
    case (state_nx)
      NS_G:    begin ns_nx = GRN; ew_nx = RED; end
      NS_Y:    begin ns_nx = YEL; ew_nx = RED; end
      EW_G:    begin ns_nx = RED; ew_nx = GRN; end
      EW_Y:    begin ns_nx = RED; ew_nx = YEL; end
      default: begin
        ns_nx = flash_nx ? YEL : OFF;
        ew_nx = flash_nx ? YEL : OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NS_G;
      cnt      <= GREEN_BCD;
      flash    <= 1'b0;
      ns_light <= GRN;
      ew_light <= RED;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      flash    <= flash_nx;
      ns_light <= ns_nx;
      ew_light <= ew_nx;
    end
  end

  assign digit_hi = cnt[7:4];
  assign digit_lo = cnt[3:0];

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed self-checking bench for traffic_ctrl with CLK_HZ=4, GREEN_S=12, YELLOW_S=3.
module tb_traffic_ctrl;

  logic       clk;
  logic       rst;
  logic       night;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [3:0] digit_hi;
  logic [3:0] digit_lo;
  logic       sec_tick;

  int checks = 0;
  int errors = 0;

  traffic_ctrl #(.CLK_HZ(4), .GREEN_S(12), .YELLOW_S(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .night    (night),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .digit_hi (digit_hi),
    .digit_lo (digit_lo),
    .sec_tick (sec_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed bundle: {ns, ew, hi, lo, tick}
  function automatic logic [14:0] pk(input logic [2:0] ns, input logic [2:0] ew,
                                     input logic [7:0] d, input logic t);
    return {ns, ew, d, t};
  endfunction

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {ns_light, ew_light, digit_hi, digit_lo, sec_tick};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed ns=%b ew=%b d=%h%h t=%b expected ns=%b ew=%b d=%h%h t=%b",
             tag, obs[14:12], obs[11:9], obs[8:5], obs[4:1], obs[0],
             exp[14:12], exp[11:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    night = 1'b0;
    step();
    rst   = 1'b0;
  endtask

  initial begin
    int rem;
    logic [2:0] ens, eew, y;

    rst   = 1'b1;
    night = 1'b0;
    step();
    step();
    chk("reset_state", pk(3'b001, 3'b100, 8'h12, 1'b0));
    rst = 1'b0;

    // First phase countdown including the 10 -> 09 borrow
    repeat (3) step();
    chk("first_tick", pk(3'b001, 3'b100, 8'h12, 1'b1));
    step();
    chk("first_dec", pk(3'b001, 3'b100, 8'h11, 1'b0));
    repeat (4) step();
    chk("dec_to_10", pk(3'b001, 3'b100, 8'h10, 1'b0));
    repeat (4) step();
    chk("borrow_09", pk(3'b001, 3'b100, 8'h09, 1'b0));

    // Full cycle, every cycle checked
    do_reset();
    for (int c = 1; c <= 120; c++) begin
      step();
      if (c < 48)       begin ens = 3'b001; eew = 3'b100; rem = 12 - c / 4;         end
      else if (c < 60)  begin ens = 3'b010; eew = 3'b100; rem = 3 - (c - 48) / 4;   end
      else if (c < 108) begin ens = 3'b100; eew = 3'b001; rem = 12 - (c - 60) / 4;  end
      else if (c < 120) begin ens = 3'b100; eew = 3'b010; rem = 3 - (c - 108) / 4;  end
      else              begin ens = 3'b001; eew = 3'b100; rem = 12 - (c - 120) / 4; end
      chk($sformatf("cycle_%0d", c), pk(ens, eew, bcd(rem), (c % 4) == 3));
    end

    // Night entry mid-EW_G, flashing, then exit
    do_reset();
    repeat (64) step();
    chk("ew_g_mid", pk(3'b100, 3'b001, 8'h11, 1'b0));
    night = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      y = (((k - 1) / 4) % 2 == 0) ? 3'b010 : 3'b000;
      chk($sformatf("night_%0d", k), pk(y, y, 8'hFF, ((k - 1) % 4) == 3));
    end
    night = 1'b0;
    step();
    chk("night_exit", pk(3'b001, 3'b100, 8'h12, 1'b0));
    repeat (3) step();
    chk("exit_first_tick", pk(3'b001, 3'b100, 8'h12, 1'b1));
    step();
    chk("exit_first_dec", pk(3'b001, 3'b100, 8'h11, 1'b0));

    // Night coincident with the phase-ending tick
    do_reset();
    repeat (47) step();
    chk("last_sec_tick", pk(3'b001, 3'b100, 8'h01, 1'b1));
    night = 1'b1;
    step();
    chk("night_over_tick", pk(3'b010, 3'b010, 8'hFF, 1'b0));
    night = 1'b0;
    step();
    chk("coinc_exit", pk(3'b001, 3'b100, 8'h12, 1'b0));
    repeat (3) step();
    chk("coinc_first_tick", pk(3'b001, 3'b100, 8'h12, 1'b1));
    step();
    chk("coinc_first_dec", pk(3'b001, 3'b100, 8'h11, 1'b0));

    // Reset mid-NS_Y restarts the prescaler
    do_reset();
    repeat (50) step();
    chk("ns_y_mid", pk(3'b010, 3'b100, 8'h03, 1'b0));
    rst = 1'b1;
    step();
    chk("reset_mid_ns_y", pk(3'b001, 3'b100, 8'h12, 1'b0));
    rst = 1'b0;
    repeat (3) step();
    chk("rst_first_tick", pk(3'b001, 3'b100, 8'h12, 1'b1));
    step();
    chk("rst_first_dec", pk(3'b001, 3'b100, 8'h11, 1'b0));

    // Reset overrides night; NIGHT follows one cycle after release
    rst   = 1'b1;
    night = 1'b1;
    step();
    chk("rst_over_night", pk(3'b001, 3'b100, 8'h12, 1'b0));
    rst = 1'b0;
    step();
    chk("night_after_rst", pk(3'b010, 3'b010, 8'hFF, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
